// File: rtl/board_io_pkg.sv
// Shared constants and helpers for board-level pushbutton handling in the clk_27 domain.
// Holds a clog2 helper, the default debounce and auto-repeat timings for a 27 MHz clock,
// and the counter widths derived from those defaults.
package board_io_pkg;

  // Bits needed to hold the values 0..value-1. Never returns less than 1.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // 10 ms, 0.5 s and 0.1 s at 27 MHz
  localparam int DB_CYCLES_27M     = 270000;
  localparam int REPEAT_DELAY_27M  = 13500000;
  localparam int REPEAT_PERIOD_27M = 2700000;

  localparam int DB_CW_27M  = clog2(DB_CYCLES_27M);
  localparam int RPT_CW_27M = clog2(max2(REPEAT_DELAY_27M, REPEAT_PERIOD_27M));

endpackage

// File: rtl/debounce_channel.sv
// One debounced pushbutton: 2-flop synchroniser, stability counter, press/release pulses.
// Latency: a steady raw change shows on pb_state and its pulse DB_CYCLES+2 edges after first sampled.
// No backpressure: pulses are single-cycle and must be consumed when asserted.
// Ports: clk_27/reset_L clock and async active-low reset; pb_raw raw line; pb_state clean level
// (1 = pressed); pb_down/pb_up one-cycle pulses; state_nxt is the next pb_state value.
// With PB_AUTO_REPEAT_EN defined a hold counter adds repeat pb_down pulses while pressed.
module debounce_channel
  import board_io_pkg::*;
#(
  parameter int DB_CYCLES     = DB_CYCLES_27M,
  parameter bit ACTIVE_LOW_IN = 1'b1,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_27M,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_27M
) (
  input  logic clk_27,
  input  logic reset_L,
  input  logic pb_raw,
  output logic pb_state,
  output logic pb_down,
  output logic pb_up,
  output logic state_nxt
);

  localparam int            CW       = clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] db_cnt;
  logic          state_q;
  logic          down_q;
  logic          up_q;
  logic          pressed;
  logic          differ;
  logic          accept;
  logic          rpt_fire;

  assign pressed   = sync_2 ^ ACTIVE_LOW_IN;
  assign differ    = pressed ^ state_q;
  // The counter only reaches CNT_LAST after DB_CYCLES-1 differing cycles, so the
  // DB_CYCLES-th consecutive differing cycle is the one that flips the level.
  assign accept    = differ && (db_cnt == CNT_LAST);
  assign state_nxt = state_q ^ accept;

  always_ff @(posedge clk_27 or negedge reset_L) begin
    if (!reset_L) begin
      // Sync flops start at the released level so reset exit never looks like a press.
      sync_1  <= ACTIVE_LOW_IN;
      sync_2  <= ACTIVE_LOW_IN;
      db_cnt  <= '0;
      state_q <= 1'b0;
      down_q  <= 1'b0;
      up_q    <= 1'b0;
    end else begin
      sync_1  <= pb_raw;
      sync_2  <= sync_1;
      if (!differ || accept) db_cnt <= '0;
      else                   db_cnt <= db_cnt + 1'b1;
      state_q <= state_nxt;
      down_q  <= (accept & ~state_q) | rpt_fire;
      up_q    <= accept & state_q;
    end
  end

`ifdef PB_AUTO_REPEAT_EN
  localparam int            RW          = clog2(max2(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rpt_cnt;
  logic          rpt_armed;  // 0 while waiting out the initial delay, 1 once repeating

  // Suppressed on the release-accept cycle so a repeat never lands with pb_up.
  assign rpt_fire = state_q && !accept &&
                    (rpt_cnt == (rpt_armed ? PERIOD_LAST : DELAY_LAST));

  always_ff @(posedge clk_27 or negedge reset_L) begin
    if (!reset_L) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b0;
    end else if (!state_q || accept) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b0;
    end else if (rpt_fire) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b1;
    end else begin
      rpt_cnt   <= rpt_cnt + 1'b1;
    end
  end
`else
  assign rpt_fire = 1'b0;

  // Repeat timings have no hardware in this build.
  logic unused_rpt_cfg;
  assign unused_rpt_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

  assign pb_state = state_q;
  assign pb_down  = down_q;
  assign pb_up    = up_q;

endmodule

// File: rtl/pushbutton_debounce_bank.sv
// Bank of NUM_CH independent debounced pushbuttons with press/release pulses and a pressed-any flag.
// Latency: DB_CYCLES+2 edges from first sample of a steady raw change to pb_state/pulse/pb_any.
// No backpressure: all outputs are registered levels or one-cycle pulses.
// Ports: clk_27 clock; reset_L async active-low reset; pb_raw raw lines (polarity per ACTIVE_LOW_IN);
// pb_state debounced levels (1 = pressed); pb_down/pb_up per-channel pulses; pb_any OR of pb_state.
// Optional macro PB_AUTO_REPEAT_EN enables auto-repeat pb_down pulses while a button is held.
module pushbutton_debounce_bank
  import board_io_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int DB_CYCLES     = DB_CYCLES_27M,
  parameter int ACTIVE_LOW_IN = 1,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_27M,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_27M
) (
  input  logic              clk_27,
  input  logic              reset_L,
  input  logic [NUM_CH-1:0] pb_raw,
  output logic [NUM_CH-1:0] pb_state,
  output logic [NUM_CH-1:0] pb_down,
  output logic [NUM_CH-1:0] pb_up,
  output logic              pb_any
);

  logic [NUM_CH-1:0] state_nxt;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    debounce_channel #(
      .DB_CYCLES     (DB_CYCLES),
      .ACTIVE_LOW_IN (ACTIVE_LOW_IN != 0),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_ch (
      .clk_27    (clk_27),
      .reset_L   (reset_L),
      .pb_raw    (pb_raw[ch]),
      .pb_state  (pb_state[ch]),
      .pb_down   (pb_down[ch]),
      .pb_up     (pb_up[ch]),
      .state_nxt (state_nxt[ch])
    );
  end

  // Built from next-state values so pb_any moves on the same edge as pb_state.
  always_ff @(posedge clk_27 or negedge reset_L) begin
    if (!reset_L) pb_any <= 1'b0;
    else          pb_any <= |state_nxt;
  end

endmodule

// File: tb/tb_pushbutton_debounce_bank.sv
module tb_pushbutton_debounce_bank;

  localparam int NCH = 4;

  logic           clk_27 = 1'b0;
  logic           reset_L = 1'b1;
  logic [NCH-1:0] pb_raw = 4'b1111;
  logic [NCH-1:0] pb_state, pb_down, pb_up;
  logic           pb_any;

  always #5 clk_27 = ~clk_27;

  pushbutton_debounce_bank #(
    .NUM_CH        (NCH),
    .DB_CYCLES     (8),
    .ACTIVE_LOW_IN (1),
    .REPEAT_DELAY  (20),
    .REPEAT_PERIOD (5)
  ) dut (
    .clk_27   (clk_27),
    .reset_L  (reset_L),
    .pb_raw   (pb_raw),
    .pb_state (pb_state),
    .pb_down  (pb_down),
    .pb_up    (pb_up),
    .pb_any   (pb_any)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  int             dn_cnt[NCH];
  int             up_cnt[NCH];
  logic [NCH-1:0] prev_dn = '0;
  logic [NCH-1:0] prev_up = '0;

  task automatic clear_counts();
    for (int c = 0; c < NCH; c++) begin
      dn_cnt[c] = 0;
      up_cnt[c] = 0;
    end
  endtask

  // Advance n cycles, sampling 1 ns after each rising edge, tallying pulses
  // and checking the pulse rules every cycle.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_27);
      #1;
      chk("dn_up_overlap", int'(pb_down & pb_up), 0);
      chk("dn_back_to_back", int'(pb_down & prev_dn), 0);
      chk("up_back_to_back", int'(pb_up & prev_up), 0);
      for (int c = 0; c < NCH; c++) begin
        dn_cnt[c] += int'(pb_down[c]);
        up_cnt[c] += int'(pb_up[c]);
      end
      prev_dn = pb_down;
      prev_up = pb_up;
    end
  endtask

  typedef struct {
    logic [NCH-1:0] raw;
    int             cycles;
    logic [NCH-1:0] st;   // pb_state after the row
    logic [NCH-1:0] dn;   // channels expected to give exactly one pb_down in the row
    logic [NCH-1:0] up;   // channels expected to give exactly one pb_up in the row
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  initial begin
    int exp_st, exp_dn, exp_up;

    // Edge 1 samples the new raw value; acceptance lands on edge 10.
    vecs[0]  = '{4'b1111, 50, 4'b0000, 4'b0000, 4'b0000};
    vecs[1]  = '{4'b1110,  9, 4'b0000, 4'b0000, 4'b0000};
    vecs[2]  = '{4'b1110,  1, 4'b0001, 4'b0001, 4'b0000};
    vecs[3]  = '{4'b1110,  5, 4'b0001, 4'b0000, 4'b0000};
    vecs[4]  = '{4'b1111,  9, 4'b0001, 4'b0000, 4'b0000};
    vecs[5]  = '{4'b1111,  1, 4'b0000, 4'b0000, 4'b0001};
    vecs[6]  = '{4'b1111,  5, 4'b0000, 4'b0000, 4'b0000};
    vecs[7]  = '{4'b0011,  9, 4'b0000, 4'b0000, 4'b0000};
    vecs[8]  = '{4'b0011,  1, 4'b1100, 4'b1100, 4'b0000};
    vecs[9]  = '{4'b1111, 10, 4'b0000, 4'b0000, 4'b1100};
    vecs[10] = '{4'b1111,  5, 4'b0000, 4'b0000, 4'b0000};
    // Exactly DB_CYCLES synchronised low cycles: accepted, then released.
    vecs[11] = '{4'b1101,  8, 4'b0000, 4'b0000, 4'b0000};
    vecs[12] = '{4'b1111, 12, 4'b0000, 4'b0010, 4'b0010};

    // Reset state
    #2 reset_L = 1'b0;
    repeat (3) @(posedge clk_27);
    #1;
    chk("reset pb_state", int'(pb_state), 0);
    chk("reset pb_down", int'(pb_down), 0);
    chk("reset pb_up", int'(pb_up), 0);
    chk("reset pb_any", int'(pb_any), 0);
    reset_L = 1'b1;

    // Table-driven rows
    for (int r = 0; r < NV; r++) begin
      pb_raw = vecs[r].raw;
      clear_counts();
      run(vecs[r].cycles);
      chk($sformatf("row%0d pb_state", r), int'(pb_state), int'(vecs[r].st));
      chk($sformatf("row%0d pb_any", r), int'(pb_any), int'(|vecs[r].st));
      for (int c = 0; c < NCH; c++) begin
        chk($sformatf("row%0d dn_ch%0d", r, c), dn_cnt[c], int'(vecs[r].dn[c]));
        chk($sformatf("row%0d up_ch%0d", r, c), up_cnt[c], int'(vecs[r].up[c]));
      end
    end

    // Glitches of DB_CYCLES-1 synchronised cycles on channel 1, five times
    clear_counts();
    for (int g = 0; g < 5; g++) begin
      pb_raw = 4'b1101;
      run(7);
      pb_raw = 4'b1111;
      run(4);
      chk($sformatf("glitch%0d state_ch1", g), int'(pb_state[1]), 0);
    end
    chk("glitch dn_ch1", dn_cnt[1], 0);
    chk("glitch up_ch1", up_cnt[1], 0);
    chk("glitch pb_any", int'(pb_any), 0);
    run(5);

    // Channel 0 held, reset asserted mid-hold
    pb_raw = 4'b1110;
    clear_counts();
    run(12);
    chk("hold pre-reset state", int'(pb_state), 1);
    chk("hold pre-reset dn_ch0", dn_cnt[0], 1);
    run(4);
    #3 reset_L = 1'b0;
    #1;
    chk("async reset pb_state", int'(pb_state), 0);
    chk("async reset pb_any", int'(pb_any), 0);
    repeat (3) begin
      @(posedge clk_27);
      #1;
      chk("in reset pb_state", int'(pb_state), 0);
      chk("in reset pb_down", int'(pb_down), 0);
      chk("in reset pb_up", int'(pb_up), 0);
    end
    reset_L = 1'b1;

    // k counts edges after reset exit. Press accepted at k=10; raw released
    // before edge 71, so release is accepted at k=80. Repeats (if built) at
    // 20, 25, ... cycles after acceptance until the release is accepted.
    for (int k = 1; k <= 85; k++) begin
      if (k == 71) pb_raw = 4'b1111;
      @(posedge clk_27);
      #1;
      exp_st = (k >= 10 && k < 80) ? 1 : 0;
      exp_dn = (k == 10) ? 1 : 0;
`ifdef PB_AUTO_REPEAT_EN
      if (k >= 30 && k < 80 && ((k - 10) % 5) == 0) exp_dn = 1;
`endif
      exp_up = (k == 80) ? 1 : 0;
      chk($sformatf("hold k=%0d pb_state", k), int'(pb_state), exp_st);
      chk($sformatf("hold k=%0d pb_down", k), int'(pb_down), exp_dn);
      chk($sformatf("hold k=%0d pb_up", k), int'(pb_up), exp_up);
      chk($sformatf("hold k=%0d pb_any", k), int'(pb_any), exp_st);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
